// File: rtl/text_scroller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_scroller_pkg
// Description : Constants and helpers shared by the text scroller and the
//               4-digit ASCII seven-segment display driver it feeds.
//               Contents:
//                 ASCII_SPACE - blank character code
//                 BLANK_WORD  - four blank characters, one display word
//                 CLK_HZ      - system clock frequency
//                 pack_chars  - joins four characters, leftmost digit first
// Revision    : 1.0 - initial release
// ============================================================================
package text_scroller_pkg;

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [31:0] BLANK_WORD  = 32'h20202020;
  localparam int unsigned CLK_HZ      = 100000000;

  // Leftmost digit ends up in bits 31:24, which is the order the display
  // driver scans its digits in.
  function automatic logic [31:0] pack_chars(input logic [7:0] c0,
                                             input logic [7:0] c1,
                                             input logic [7:0] c2,
                                             input logic [7:0] c3);
    return {c0, c1, c2, c3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_scroller_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Periodic one-cycle enable pulse. Counts 0..TICKS-1 while en
//               is high and pulses tick during the last count; the count is
//               held at 0 while en is low, so the first pulse arrives TICKS
//               cycles after en rises. Used as a clock enable rather than as
//               a derived clock.
// Ports       : clk   in  system clock
//               reset in  asynchronous active-high reset
//               en    in  count enable; low holds the count at 0
//               tick  out one-cycle pulse every TICKS enabled cycles
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
  import text_scroller_pkg::*;
#(
  parameter int TICKS = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int            CNT_W = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Gated by en so that dropping en in the terminal cycle suppresses the pulse.
  assign tick = en && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/text_scroller.sv
`default_nettype none
// ============================================================================
// Module      : text_scroller
// Description : Marquee source for the 4-digit ASCII display driver. Stores
//               up to DEPTH characters and presents a registered 4-character
//               window that scrolls through the message followed by four
//               blank pads. Scrolling advances on an internal step timer
//               while run is high, or on single step pulses.
// Ports       : clk      in   system clock
//               reset    in   asynchronous active-high reset
//               wr_en    in   append wr_char this cycle
//               wr_char  in   [7:0] character to append
//               clear    in   synchronous clear of buffer and scroll state
//               run      in   level, enables automatic scrolling
//               step     in   one-cycle pulse, advance the window by one
//               word     out  [31:0] display word, [31:24] = leftmost char
//               len      out  characters currently stored
//               full     out  len == DEPTH
//               overflow out  sticky, a write was attempted while full
// Revision    : 1.0 - initial release
// ============================================================================
module text_scroller
  import text_scroller_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int STEP_TICKS = 25000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_char,
  input  logic                     clear,
  input  logic                     run,
  input  logic                     step,
  output logic [31:0]              word,
  output logic [$clog2(DEPTH):0]   len,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // Position arithmetic width: covers the virtual length DEPTH+4 and the
  // unreduced pos+3 sum before its modulo correction.
  localparam int CW = AW + 3;

  logic [7:0]    msg_buf [DEPTH];
  logic [CW-1:0] pos;
  logic [CW-1:0] vlen;
  logic [CW-1:0] pos_next;
  logic [31:0]   window;
  logic          tick;
  logic          tick_en;
  logic          advance;
  logic          write_ok;

  // Clearing the timer through its enable keeps tick_gen's port list
  // minimal: a low enable already forces the count back to 0.
  assign tick_en = run && !clear;

  tick_gen #(
    .TICKS (STEP_TICKS)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .tick  (tick)
  );

  // Virtual message length: stored characters plus four blank pads.
  assign vlen     = CW'(len) + CW'(4);
  assign full     = (len == LW'(DEPTH));
  assign write_ok = wr_en && !full;
  // A coincident tick and step collapse into a single advance; an empty
  // buffer pins the window at position 0.
  assign advance  = (tick || step) && (len != '0);
  assign pos_next = (pos == vlen - CW'(1)) ? '0 : pos + CW'(1);

  // Window character g sits at (pos+g) mod vlen. Since pos < vlen and
  // g <= 3 < vlen, one conditional subtraction performs the modulo.
  // Indices at or beyond len fall in the pad region and read as blanks.
  for (genvar g = 0; g < 4; g++) begin : g_window
    logic [CW-1:0] raw_idx;
    logic [CW-1:0] idx;
    assign raw_idx = pos + CW'(g);
    assign idx     = (raw_idx >= vlen) ? raw_idx - vlen : raw_idx;
    assign window[31-8*g -: 8] = (idx < CW'(len)) ? msg_buf[idx[AW-1:0]]
                                                   : ASCII_SPACE;
  end

  // Message storage carries no reset; len alone defines which entries are
  // meaningful.
  always_ff @(posedge clk) begin
    if (write_ok && !clear) begin
      msg_buf[len[AW-1:0]] <= wr_char;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len      <= '0;
      pos      <= '0;
      overflow <= 1'b0;
      word     <= BLANK_WORD;
    end else begin
      // The word follows the state registers by one cycle.
      word <= window;
      if (clear) begin
        len      <= '0;
        pos      <= '0;
        overflow <= 1'b0;
      end else begin
        // pos wraps against the current len; a write landing in this same
        // cycle only lengthens the message from the next cycle on.
        if (advance) begin
          pos <= pos_next;
        end
        if (write_ok) begin
          len <= len + LW'(1);
        end else if (wr_en) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_scroller
// Description : Self-checking bench for text_scroller. A queue-based model
//               of the virtual message tracks expected outputs; directed
//               scenarios also compare against literal expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_scroller;

  localparam int DEPTH = 16;
  localparam int T     = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_char = 8'h00;
  logic        clear = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [31:0] word;
  logic [4:0]  len;
  logic        full;
  logic        overflow;

  int checks = 0;
  int passes = 0;

  text_scroller #(.DEPTH(DEPTH), .STEP_TICKS(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_char  (wr_char),
    .clear    (clear),
    .run      (run),
    .step     (step),
    .word     (word),
    .len      (len),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  q[$];
  int          mpos;
  int          mcnt;
  bit          mov;
  logic [31:0] mword;

  function automatic logic [31:0] mwin();
    logic [31:0] w;
    int n;
    w = 32'h0;
    n = q.size() + 4;
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (mpos + i) % n;
      w[31-8*i -: 8] = (idx < q.size()) ? q[idx] : 8'h20;
    end
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    mpos  = 0;
    mcnt  = 0;
    mov   = 1'b0;
    mword = 32'h20202020;
  endtask

  task automatic model_step();
    logic [31:0] nw;
    bit tk;
    nw = mwin();
    tk = run && (mcnt == T - 1);
    if (clear) begin
      q.delete();
      mpos = 0;
      mcnt = 0;
      mov  = 1'b0;
    end else begin
      mcnt = run ? ((mcnt == T - 1) ? 0 : mcnt + 1) : 0;
      if ((tk || step) && q.size() > 0) mpos = (mpos + 1) % (q.size() + 4);
      if (wr_en) begin
        if (q.size() < DEPTH) q.push_back(wr_char);
        else mov = 1'b1;
      end
    end
    mword = nw;
  endtask

  // One clock: model consumes the inputs at the rising edge, outputs are
  // then sampled at the falling edge where new inputs are driven.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (word !== 32'h20202020) $display("FAIL reset_word: got %h expected 20202020", word); else passes++;
    checks++; if (len !== 5'd0) $display("FAIL reset_len: got %0d expected 0", len); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passes++;
    model_reset();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_write_hello();
    string s;
    s = "hello";
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_char = s[i];
      cycle();
    end
    wr_en = 1'b0;
    checks++; if (len !== 5'd5) $display("FAIL hello_len: got %0d expected 5", len); else passes++;
    cycle();
    checks++; if (word !== 32'h68656C6C) $display("FAIL hello_word: got %h expected 68656c6c", word); else passes++;
    checks++; if (word !== mword) $display("FAIL hello_model: got %h expected %h", word, mword); else passes++;
  endtask

  task automatic test_step_scroll();
    logic [31:0] exp_w [9];
    exp_w = '{32'h656C6C6F, 32'h6C6C6F20, 32'h6C6F2020, 32'h6F202020, 32'h20202020,
              32'h20202068, 32'h20206865, 32'h2068656C, 32'h68656C6C};
    for (int k = 0; k < 9; k++) begin
      step = 1'b1;
      cycle();
      step = 1'b0;
      cycle();
      checks++; if (word !== exp_w[k]) $display("FAIL step_word%0d: got %h expected %h", k, word, exp_w[k]); else passes++;
      checks++; if (word !== mword) $display("FAIL step_model%0d: got %h expected %h", k, word, mword); else passes++;
    end
  endtask

  task automatic test_tick_coincident();
    run = 1'b1;
    cycle(); cycle(); cycle();
    step = 1'b1;              // lands on the same edge as the first tick
    cycle();
    step = 1'b0;
    cycle();
    checks++; if (word !== 32'h656C6C6F) $display("FAIL coincide_word: got %h expected 656c6c6f", word); else passes++;
    cycle(); cycle(); cycle();
    checks++; if (word !== 32'h656C6C6F) $display("FAIL tick_early: got %h expected 656c6c6f", word); else passes++;
    cycle();
    checks++; if (word !== 32'h6C6C6F20) $display("FAIL tick_period: got %h expected 6c6c6f20", word); else passes++;
    checks++; if (word !== mword) $display("FAIL tick_model: got %h expected %h", word, mword); else passes++;
    run = 1'b0;
    cycle();
  endtask

  task automatic test_full_overflow();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_char = (i == 16) ? 8'h7A : 8'h61;
      cycle();
    end
    wr_en = 1'b0;
    checks++; if (len !== 5'd16) $display("FAIL full_len: got %0d expected 16", len); else passes++;
    checks++; if (full !== 1'b1) $display("FAIL full_flag: got %b expected 1", full); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL overflow_flag: got %b expected 1", overflow); else passes++;
    cycle();
    checks++; if (word !== 32'h61616161) $display("FAIL full_word: got %h expected 61616161", word); else passes++;
    clear = 1'b1; wr_en = 1'b1; wr_char = 8'h62;
    cycle();
    clear = 1'b0; wr_en = 1'b0;
    checks++; if (len !== 5'd0) $display("FAIL clear_len: got %0d expected 0", len); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL clear_overflow: got %b expected 0", overflow); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL clear_full: got %b expected 0", full); else passes++;
    cycle();
    checks++; if (word !== 32'h20202020) $display("FAIL clear_word: got %h expected 20202020", word); else passes++;
  endtask

  task automatic test_empty_run();
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step = i[0];
      cycle();
      checks++; if (word !== 32'h20202020) $display("FAIL empty_word%0d: got %h expected 20202020", i, word); else passes++;
    end
    step = 1'b0;
    checks++; if (len !== 5'd0) $display("FAIL empty_len: got %0d expected 0", len); else passes++;
    wr_en = 1'b1; wr_char = 8'h78;
    cycle();
    wr_en = 1'b0;
    cycle();
    checks++; if (word !== 32'h78202020) $display("FAIL empty_write_word: got %h expected 78202020", word); else passes++;
    checks++; if (word !== mword) $display("FAIL empty_model: got %h expected %h", word, mword); else passes++;
    run = 1'b0;
    cycle();
  endtask

  task automatic test_reset_midrun();
    string s;
    s = "hello";
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_char = s[i];
      cycle();
    end
    wr_en = 1'b0;
    step = 1'b1;
    cycle(); cycle(); cycle();
    step = 1'b0;
    run = 1'b1;
    cycle();
    checks++; if (word !== mword) $display("FAIL midrun_pre_word: got %h expected %h", word, mword); else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (word !== 32'h20202020) $display("FAIL async_word: got %h expected 20202020", word); else passes++;
    checks++; if (len !== 5'd0) $display("FAIL async_len: got %0d expected 0", len); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL async_full: got %b expected 0", full); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL async_overflow: got %b expected 0", overflow); else passes++;
    model_reset();
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom % 4) == 0;
      wr_char = 8'(8'h21 + ($urandom % 90));
      clear   = ($urandom % 97) == 0;
      step    = ($urandom % 5) == 0;
      if (($urandom % 23) == 0) run = ~run;
      cycle();
      checks++; if (word !== mword) $display("FAIL rand_word@%0d: got %h expected %h", i, word, mword); else passes++;
      checks++; if (len !== 5'(q.size())) $display("FAIL rand_len@%0d: got %0d expected %0d", i, len, q.size()); else passes++;
      checks++; if (full !== (q.size() == DEPTH)) $display("FAIL rand_full@%0d: got %b expected %b", i, full, q.size() == DEPTH); else passes++;
      checks++; if (overflow !== mov) $display("FAIL rand_overflow@%0d: got %b expected %b", i, overflow, mov); else passes++;
    end
    wr_en = 1'b0; clear = 1'b0; step = 1'b0; run = 1'b0;
    cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_hello();
    test_step_scroll();
    test_tick_coincident();
    test_full_overflow();
    test_empty_run();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_scroller.md
Name: text_scroller

Overview:
- Marquee source for the 4-digit ASCII seven-segment display driver; sits directly upstream of it.
- Holds up to DEPTH ASCII characters and emits a registered 32-bit word, leftmost digit in bits 31:24.
- The word is a 4-character window that scrolls through the message followed by 4 blank pads.
- Advances on a free-running step timer when run is high, or on single-step pulses (e.g. from a push-button click detector).

Parameters:
- DEPTH, 16, message buffer capacity in characters (power of two, 4..64).
- STEP_TICKS, 25000000, clk cycles per automatic scroll step (0.25 s at 100 MHz); must be >= 2.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  append wr_char to buffer this cycle
- wr_char  in  8  ASCII character to append
- clear  in  1  synchronous clear: empty buffer, reset scroll position
- run  in  1  level; enables automatic scrolling
- step  in  1  one-cycle pulse; advance the window by one
- word  out  32  display word, [31:24]=leftmost char
- len  out  $clog2(DEPTH)+1  characters currently stored
- full  out  1  len == DEPTH
- overflow  out  1  sticky; a write was attempted while full

Behaviour:
- Reset (async, active-high):
  - len=0, pos=0, tick counter=0
  - word=32'h20202020, full=0, overflow=0
  - buffer contents are don't-care
- Virtual message: vmsg = buf[0..len-1] followed by 4 x 8'h20; L = len+4.
- Window: word <= {vmsg[pos], vmsg[(pos+1)%L], vmsg[(pos+2)%L], vmsg[(pos+3)%L]}.
  - Registered: word reflects state one cycle after any change to pos, len or buffer.
- Write: wr_en && !full -> buf[len]<=wr_char, len<=len+1.
  - wr_en && full -> buffer unchanged, overflow<=1.
- Clear: clear -> len=0, pos=0, tick counter=0, overflow=0.
  - clear beats wr_en, step and tick in the same cycle.
- Tick timer:
  - Counter width $clog2(STEP_TICKS); counts 0..STEP_TICKS-1 while run=1, tick pulse at STEP_TICKS-1, then wraps to 0.
  - run=0 holds the counter at 0, so the first tick comes STEP_TICKS cycles after run rises.
- Advance: (tick || step) -> pos <= (pos==L-1) ? 0 : pos+1.
  - Coincident tick and step advance once only.
- Empty buffer (len=0): pos held at 0, advances ignored, word=32'h20202020.
- Write during scroll:
  - pos is unchanged.
  - L grows by one the cycle after the write; a wrap compare in that cycle uses the new L.
  - Because len only grows, pos < L always holds.
- No FSM beyond idle/scrolling implied by run; state is buffer, len, pos, tick counter.
- Characters are passed through unmodified; the display driver blanks unknown codes.

Decomposition:
- Shared package, also used by the display driver:
  - ASCII_SPACE = 8'h20
  - BLANK_WORD = 32'h20202020
  - CLK_HZ = 100000000
- Sub-module tick_gen #(TICKS): clk, reset, en -> one-cycle tick pulse.
  - Holds its count at 0 when en=0.
  - Reusable elsewhere for periodic enables instead of derived clocks.

Test Plan:
- Reset mid-run with len=5, pos=3 -> word=32'h20202020, len=0, full=0, overflow=0 immediately (asynchronous).
- Write "hello", step=0, run=0 -> len=5, word=32'h68656C6C ("hell") one cycle after the last write.
- Loaded "hello", 8 step pulses -> successive words "ello", "llo ", "lo  ", "o   ", "    ", "   h", "  he", " hel" (pos 8 = 32'h2068656C). A ninth step wraps pos to 0 -> 32'h68656C6C.
- Loaded "hello", STEP_TICKS=4, run=1, then a step pulse coincident with a tick -> pos advances by exactly one; subsequent ticks every 4 cycles.
- DEPTH=16: 17 writes of "a" -> len=16, full=1, overflow=1, buffer unchanged. Then clear and wr_en together -> len=0, overflow=0, write dropped.
- len=0 with run=1 and step pulses -> pos stays 0, word=32'h20202020. A write of "x" mid-run then yields word=32'h78202020 at the next cycle.
